// File: rtl/commit_trace_buffer.sv
// Writeback commit trace FIFO: captures retired instructions and drains them over valid/ready.
// Optional macro TRACE_BACKPRESSURE_EN adds the trace_stall output for core-side backpressure.
module commit_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_W,
  input  logic [31:0]       instr_W_TR,
  input  logic [31:0]       pc_W,
  input  logic              rd_wen_W,
  input  logic [4:0]        rd_addr_W,
  input  logic [31:0]       rd_data_W,
  input  logic              trace_clear,
  output logic              trace_valid,
  input  logic              trace_ready,
  output logic [31:0]       trace_instr,
  output logic [31:0]       trace_pc,
  output logic              trace_rd_wen,
  output logic [4:0]        trace_rd_addr,
  output logic [31:0]       trace_rd_data,
  output logic [31:0]       trace_seq,
  output logic [ADDR_W:0]   trace_count,
  output logic [63:0]       instret,
  output logic [DROP_W-1:0] drop_cnt,
`ifdef TRACE_BACKPRESSURE_EN
  output logic              trace_stall,
`endif
  output logic              overflow
);

  localparam int ENTRY_W = 32 + 32 + 1 + 5 + 32 + 32;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  // Valid/ready: an entry transfers on a rising edge where trace_valid && trace_ready;
  // while trace_valid is high and trace_ready low, the head entry is held unchanged.

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] head;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               commit;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  assign commit      = valid_W && (instr_W_TR != 32'd0);
  assign full        = (trace_count == FULL_CNT);
  assign trace_valid = (trace_count != '0);
  // A clear cycle neither stores, pops nor drops; it only lets instret count the commit.
  assign pop  = trace_valid && trace_ready && !trace_clear;
  assign push = commit && !trace_clear && (!full || pop);
  assign drop = commit && !trace_clear && full && !pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {instr_W_TR, pc_W, rd_wen_W, rd_addr_W, rd_data_W, instret[31:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
      instret     <= '0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else begin
      if (commit) begin
        instret <= instret + 64'd1;
      end
      if (trace_clear) begin
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        trace_count <= '0;
        drop_cnt    <= '0;
        overflow    <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
        if (push && !pop) begin
          trace_count <= trace_count + (ADDR_W+1)'(1);
        end else if (pop && !push) begin
          trace_count <= trace_count - (ADDR_W+1)'(1);
        end
        if (drop) begin
          overflow <= 1'b1;
          if (drop_cnt != {DROP_W{1'b1}}) begin
            drop_cnt <= drop_cnt + DROP_W'(1);
          end
        end
      end
    end
  end

  // The array is never reset, so the head is masked to zero whenever the FIFO is empty.
  assign head = trace_valid ? mem[rd_ptr] : '0;
  assign {trace_instr, trace_pc, trace_rd_wen, trace_rd_addr, trace_rd_data, trace_seq} = head;

`ifdef TRACE_BACKPRESSURE_EN
  assign trace_stall = (trace_count >= (FULL_CNT - (ADDR_W+1)'(1))) || overflow;
`endif

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: table vectors, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_commit_trace_buffer;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DROP_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              valid_W;
  logic [31:0]       instr_W_TR;
  logic [31:0]       pc_W;
  logic              rd_wen_W;
  logic [4:0]        rd_addr_W;
  logic [31:0]       rd_data_W;
  logic              trace_clear;
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_instr;
  logic [31:0]       trace_pc;
  logic              trace_rd_wen;
  logic [4:0]        trace_rd_addr;
  logic [31:0]       trace_rd_data;
  logic [31:0]       trace_seq;
  logic [ADDR_W:0]   trace_count;
  logic [63:0]       instret;
  logic [DROP_W-1:0] drop_cnt;
  logic              overflow;
`ifdef TRACE_BACKPRESSURE_EN
  logic              trace_stall;
`endif

  commit_trace_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
    .clk(clk), .rst(rst), .valid_W(valid_W), .instr_W_TR(instr_W_TR), .pc_W(pc_W),
    .rd_wen_W(rd_wen_W), .rd_addr_W(rd_addr_W), .rd_data_W(rd_data_W),
    .trace_clear(trace_clear), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_instr(trace_instr), .trace_pc(trace_pc), .trace_rd_wen(trace_rd_wen),
    .trace_rd_addr(trace_rd_addr), .trace_rd_data(trace_rd_data), .trace_seq(trace_seq),
    .trace_count(trace_count), .instret(instret), .drop_cnt(drop_cnt),
`ifdef TRACE_BACKPRESSURE_EN
    .trace_stall(trace_stall),
`endif
    .overflow(overflow)
  );

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] seq;
  } ent_t;

  ent_t        exp_q[$];
  logic [63:0] m_instret;
  int          m_drop;
  logic        m_ovf;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Applies the currently driven inputs to the model as one clock edge.
  task automatic model_step();
    logic commit;
    ent_t e;
    commit = valid_W && (instr_W_TR != 0);
    if (rst) begin
      exp_q.delete();
      m_instret = 0;
      m_drop = 0;
      m_ovf = 1'b0;
    end else if (trace_clear) begin
      exp_q.delete();
      m_drop = 0;
      m_ovf = 1'b0;
      if (commit) m_instret++;
    end else begin
      if (exp_q.size() > 0 && trace_ready) void'(exp_q.pop_front());
      if (commit) begin
        if (exp_q.size() < DEPTH) begin
          e.instr = instr_W_TR; e.pc = pc_W; e.wen = rd_wen_W;
          e.addr = rd_addr_W; e.data = rd_data_W; e.seq = m_instret[31:0];
          exp_q.push_back(e);
        end else begin
          m_ovf = 1'b1;
          if (m_drop < (1 << DROP_W) - 1) m_drop++;
        end
        m_instret++;
      end
    end
  endtask

  task automatic compare_model();
    ent_t h;
    h = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("m_valid", 64'(trace_valid), 64'(exp_q.size() > 0));
    check("m_count", 64'(trace_count), 64'(exp_q.size()));
    check("m_instr", 64'(trace_instr), 64'(h.instr));
    check("m_pc", 64'(trace_pc), 64'(h.pc));
    check("m_wen", 64'(trace_rd_wen), 64'(h.wen));
    check("m_addr", 64'(trace_rd_addr), 64'(h.addr));
    check("m_data", 64'(trace_rd_data), 64'(h.data));
    check("m_seq", 64'(trace_seq), 64'(h.seq));
    check("m_instret", instret, m_instret);
    check("m_drop", 64'(drop_cnt), 64'(m_drop));
    check("m_ovf", 64'(overflow), 64'(m_ovf));
`ifdef TRACE_BACKPRESSURE_EN
    check("m_stall", 64'(trace_stall), 64'((exp_q.size() >= DEPTH - 1) || m_ovf));
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 1'b0; valid_W = 1'b0; instr_W_TR = '0; pc_W = '0; rd_wen_W = 1'b0;
    rd_addr_W = '0; rd_data_W = '0; trace_clear = 1'b0; trace_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic drive_commit(input logic [31:0] pc, input logic [31:0] instr);
    valid_W = 1'b1; instr_W_TR = instr; pc_W = pc;
    rd_wen_W = pc[2]; rd_addr_W = pc[6:2]; rd_data_W = ~pc;
  endtask

  // Pops until empty, recording pc/seq of every entry transferred.
  logic [31:0] got_pc[$];
  logic [31:0] got_seq[$];
  task automatic drain();
    int budget;
    budget = 0;
    valid_W = 1'b0; instr_W_TR = '0; trace_ready = 1'b1;
    while (trace_valid && budget < 40) begin
      got_pc.push_back(trace_pc);
      got_seq.push_back(trace_seq);
      cycle();
      budget++;
    end
    check("drain_timeout", 64'(trace_valid), 64'd0);
    trace_ready = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        ready;
    logic        exp_valid;
    logic [4:0]  exp_count;
    logic [63:0] exp_instret;
    logic [31:0] exp_pc;
    logic [31:0] exp_seq;
  } vec_t;

  vec_t vecs[11];

  initial begin
    for (int i = 0; i < 5; i++) vecs[i] = '{1'b1, 32'h0, 32'h1234, 1'b1, 1'b0, 5'd0, 64'd0, 32'h0, 32'd0};
    vecs[5]  = '{1'b1, 32'h13, 32'h8000_0000, 1'b1, 1'b1, 5'd1, 64'd1, 32'h8000_0000, 32'd0};
    vecs[6]  = '{1'b0, 32'h13, 32'h9999_0000, 1'b0, 1'b1, 5'd1, 64'd1, 32'h8000_0000, 32'd0};
    vecs[7]  = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 5'd0, 64'd1, 32'h0,         32'd0};
    vecs[8]  = '{1'b1, 32'h33, 32'h40,        1'b0, 1'b1, 5'd1, 64'd2, 32'h40,        32'd1};
    vecs[9]  = '{1'b1, 32'h33, 32'h44,        1'b1, 1'b1, 5'd1, 64'd3, 32'h44,        32'd2};
    vecs[10] = '{1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 5'd0, 64'd3, 32'h0,         32'd0};

    idle_inputs();
    exp_q.delete(); m_instret = 0; m_drop = 0; m_ovf = 1'b0;
    do_reset();
    check("reset_valid", 64'(trace_valid), 64'd0);
    check("reset_count", 64'(trace_count), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_pc", 64'(trace_pc), 64'd0);

    // Bubbles, first commit latency, head hold, pop, push+pop.
    for (int i = 0; i < 11; i++) begin
      drive_commit(vecs[i].pc, vecs[i].instr);
      valid_W = vecs[i].v;
      trace_ready = vecs[i].ready;
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(trace_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 64'(trace_count), 64'(vecs[i].exp_count));
      check($sformatf("vec%0d_instret", i), instret, vecs[i].exp_instret);
      check($sformatf("vec%0d_pc", i), 64'(trace_pc), 64'(vecs[i].exp_pc));
      check($sformatf("vec%0d_seq", i), 64'(trace_seq), 64'(vecs[i].exp_seq));
    end

    // Overfill: 18 commits into a 16-deep FIFO with no consumer.
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive_commit(32'h100 + 32'(4 * i), 32'h13);
      cycle();
    end
    check("ovf_count", 64'(trace_count), 64'd16);
    check("ovf_drop", 64'(drop_cnt), 64'd2);
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_instret", instret, 64'd18);
    got_pc.delete(); got_seq.delete();
    drain();
    check("ovf_drain_len", 64'(got_pc.size()), 64'd16);
    for (int i = 0; i < got_pc.size(); i++) begin
      check("ovf_drain_pc", 64'(got_pc[i]), 64'(32'h100 + 32'(4 * i)));
      check("ovf_drain_seq", 64'(got_seq[i]), 64'(i));
    end
    check("ovf_sticky", 64'(overflow), 64'd1);

    // Full FIFO, commit with a same-cycle pop: no drop.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive_commit(32'h100 + 32'(4 * i), 32'h13);
      cycle();
    end
    drive_commit(32'h200, 32'h13);
    trace_ready = 1'b1;
    cycle();
    check("fullpop_count", 64'(trace_count), 64'd16);
    check("fullpop_drop", 64'(drop_cnt), 64'd0);
    check("fullpop_ovf", 64'(overflow), 64'd0);
    got_pc.delete(); got_seq.delete();
    drain();
    check("fullpop_len", 64'(got_pc.size()), 64'd16);
    if (got_pc.size() == 16) begin
      check("fullpop_last_pc", 64'(got_pc[15]), 64'h200);
      check("fullpop_last_seq", 64'(got_seq[15]), 64'd16);
      check("fullpop_first_pc", 64'(got_pc[0]), 64'h104);
    end

    // Clear with a same-cycle commit and pop request.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive_commit(32'h300 + 32'(4 * i), 32'h13);
      cycle();
    end
    drive_commit(32'h400, 32'h13);
    trace_clear = 1'b1; trace_ready = 1'b1;
    cycle();
    trace_clear = 1'b0; valid_W = 1'b0; trace_ready = 1'b0;
    check("clr_count", 64'(trace_count), 64'd0);
    check("clr_valid", 64'(trace_valid), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_drop", 64'(drop_cnt), 64'd0);
    check("clr_instret", instret, 64'd6);

    // Clear after an overflow resets drop count and flag.
    for (int i = 0; i < 17; i++) begin
      drive_commit(32'h500 + 32'(4 * i), 32'h13);
      cycle();
    end
    check("clr2_pre_ovf", 64'(overflow), 64'd1);
    valid_W = 1'b0; trace_clear = 1'b1;
    cycle();
    trace_clear = 1'b0;
    check("clr2_ovf", 64'(overflow), 64'd0);
    check("clr2_drop", 64'(drop_cnt), 64'd0);
    check("clr2_instret", instret, 64'd23);

    // Streaming commit+pop across pointer wrap.
    do_reset();
    got_pc.delete(); got_seq.delete();
    trace_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (trace_valid) got_seq.push_back(trace_seq);
      drive_commit(32'h1000 + 32'(4 * i), 32'h33);
      cycle();
      check("stream_count_le1", 64'(trace_count <= 1), 64'd1);
    end
    drain();
    check("stream_len", 64'(got_seq.size()), 64'd40);
    for (int i = 0; i < got_seq.size(); i++) check("stream_seq", 64'(got_seq[i]), 64'(i));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int phase;
      phase = (i / 150) % 3;
      drive_commit($urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom | 32'h1);
      valid_W = ($urandom_range(0, 3) != 0);
      case (phase)
        0: trace_ready = ($urandom_range(0, 7) == 0);
        1: trace_ready = ($urandom_range(0, 1) == 0);
        default: trace_ready = ($urandom_range(0, 7) != 0);
      endcase
      trace_clear = ($urandom_range(0, 99) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cycle();
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Downstream consumer of the W-stage trace instruction word. Sits after the D/E/M/W trace register chain at writeback.
- Captures each retired instruction with its PC and register-writeback info into a circular first-word-fall-through FIFO.
- Drains the FIFO over a valid/ready handshake to the difftest/debug trace port.
- Maintains a retired-instruction counter, a drop counter and a sticky overflow flag.

Parameters:
DEPTH, 16, FIFO entries; must be a power of 2, at least 2.
ADDR_W, 4, log2(DEPTH); pointer width.
DROP_W, 16, width of the saturating drop counter.

Ports:
clk  input  1  core clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
valid_W  input  1  W stage holds a retiring instruction this cycle.
instr_W_TR  input  32  W-stage trace instruction word; 0 means bubble or flushed slot.
pc_W  input  32  PC of the W-stage instruction.
rd_wen_W  input  1  register-file write enable at W.
rd_addr_W  input  5  destination register.
rd_data_W  input  32  writeback data.
trace_clear  input  1  synchronous flush of FIFO, overflow and drop count.
trace_valid  output  1  head entry available.
trace_ready  input  1  consumer accepts head entry.
trace_instr  output  32  head instruction.
trace_pc  output  32  head PC.
trace_rd_wen  output  1  head write enable.
trace_rd_addr  output  5  head destination register.
trace_rd_data  output  32  head writeback data.
trace_seq  output  32  head sequence number.
trace_count  output  ADDR_W+1  current occupancy, 0..DEPTH.
instret  output  64  retired-instruction count.
drop_cnt  output  DROP_W  commits lost to a full FIFO.
overflow  output  1  sticky; set on first drop.

Behaviour:
- Commit event: commit = valid_W && (instr_W_TR != 0). Bubbles are never recorded or counted.
- Reset (rst=1 at posedge):
  - Pointers, trace_count, instret, drop_cnt and overflow go to 0.
  - trace_valid=0. All trace_* data outputs read 0.
  - rst has priority over all other inputs, including mid-handshake.
- Pop: occurs when trace_valid && trace_ready; read pointer advances.
- Push:
  - Occurs on commit when trace_count<DEPTH, or when trace_count==DEPTH and a pop happens the same cycle.
  - Writes {instr, pc, rd_wen, rd_addr, rd_data, seq=instret[31:0]} at the write pointer.
- Pointers wrap modulo DEPTH. trace_count tracks occupancy; simultaneous push+pop leaves it unchanged.
- Latency: a commit into an empty FIFO gives trace_valid=1 on the next cycle, with the entry's fields on trace_*.
  - No same-cycle bypass.
- Head stability: trace_* data is stable while trace_valid && !trace_ready.
- When trace_valid=0, trace_* data reads 0.
- instret increments by 1 on every commit, dropped or not. Wraps at 2^64. Unaffected by trace_clear.
- Drop, when full with no pop and a commit:
  - Entry is discarded.
  - drop_cnt increments, saturating at all-ones.
  - overflow is set and stays set until rst or trace_clear.
  - The sequence gap is visible to the consumer via trace_seq.
- trace_clear:
  - Empties the FIFO and zeroes drop_cnt and overflow.
  - A commit in the same cycle is counted in instret but not stored.
  - A pop in the same cycle is ignored.
- Entry storage may be flop or distributed RAM. No reset of the array is required, since outputs are gated by trace_valid.

Optional Feature:
- Macro: TRACE_BACKPRESSURE_EN.
- Defined:
  - Adds output port trace_stall (1 bit). trace_stall = (trace_count >= DEPTH-1) || overflow.
  - The core uses trace_stall to freeze valid_M, so a full FIFO never sees a commit.
  - If a commit still arrives when full, it is dropped as above and overflow flags the protocol violation.
- Undefined: trace_stall does not exist; behaviour is drop-on-full as described.

Test Plan:
1. Reset, then valid_W=1, instr=0x00000013, pc=0x80000000 with trace_ready=1.
   -> Next cycle trace_valid=1, trace_pc=0x80000000, trace_seq=0. instret=1 after the edge.
2. valid_W=1 with instr_W_TR=0 for 5 cycles.
   -> trace_valid stays 0; instret and trace_count stay 0.
3. trace_ready=0, 18 consecutive commits with pc=0x100+4*i (DEPTH=16).
   -> trace_count=16, drop_cnt=2, overflow=1, instret=18.
   -> Draining yields pcs 0x100..0x13C with seq 0..15.
4. FIFO full, same cycle commit pc=0x200 and trace_ready=1.
   -> No drop. trace_count stays 16. The last drained entry is pc=0x200, seq=16.
5. Fill 5 entries, then assert trace_clear with a commit.
   -> trace_count=0, trace_valid=0, overflow=0, drop_cnt=0. instret increments by 6 in total.
6. Continuous commit + pop for 40 cycles with DEPTH=16, crossing pointer wrap.
   -> trace_seq is contiguous 0..39 in order; trace_count stays ≤1.
